// File: rtl/clk_mon_pkg.sv
// -----------------------------------------------------------------------------
// clk_mon_pkg
// Shared definitions for the divided-clock monitor:
//   mon_state_t    - monitor FSM states
//   ERR_CNT_W      - width of the saturating fault counter
//   stall_timeout  - cycles without a rising edge before a stall is declared
// -----------------------------------------------------------------------------
package clk_mon_pkg;

  typedef enum logic [1:0] {
    S_WAIT    = 2'd0,
    S_MEASURE = 2'd1,
    S_STALL   = 2'd2
  } mon_state_t;

  localparam int ERR_CNT_W = 16;

  // A stall is declared after two full expected periods with no rising edge.
  function automatic int stall_timeout(input int div);
    return 2 * div;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// -----------------------------------------------------------------------------
// rise_detect
// Registers a level signal and flags the cycle in which it goes 0 -> 1.
// The input must already be synchronous to clk.
// Ports:
//   clk  in  clock, posedge
//   rst  in  asynchronous active-high reset (clears the history register)
//   d    in  level to watch
//   rise out d=1 while the registered copy is 0 (combinational, same cycle)
// -----------------------------------------------------------------------------
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d;
    end
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/clk_div_monitor.sv
// -----------------------------------------------------------------------------
// clk_div_monitor
// Measures the period and high time of one divided clock (in clk_in cycles),
// checks them against the expected ratio, and reports lock, errors and stalls.
// Ports:
//   clk_in      in   system clock, all logic on posedge
//   rst         in   asynchronous active-high reset
//   div_clk     in   monitored divided clock (synchronous to clk_in)
//   clear       in   synchronous clear of error/lock state and FSM
//   period      out  last measured period
//   high_time   out  last measured high time
//   meas_valid  out  one-cycle pulse when period/high_time update
//   locked      out  LOCK_COUNT consecutive good periods since last fault
//   err         out  sticky fault flag
//   err_count   out  saturating fault count
//   stalled     out  no rising edge within 2*DIV cycles
// -----------------------------------------------------------------------------
module clk_div_monitor
  import clk_mon_pkg::*;
#(
  parameter int DIV        = 4,
  parameter int HIGH_EXP   = DIV / 2,
  parameter int HIGH_TOL   = 0,
  parameter int LOCK_COUNT = 4,
  parameter int CNT_W      = 8
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 div_clk,
  input  logic                 clear,
  output logic [CNT_W-1:0]     period,
  output logic [CNT_W-1:0]     high_time,
  output logic                 meas_valid,
  output logic                 locked,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 stalled
);

  localparam int RUN_W = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(stall_timeout(DIV));
  localparam logic [CNT_W-1:0] DIV_C   = CNT_W'(DIV);
  localparam logic [CNT_W-1:0] HI_MAX  = CNT_W'(HIGH_EXP + HIGH_TOL);
  // Lower bound clamped at zero so the window test never underflows.
  localparam logic [CNT_W-1:0] HI_MIN  = (HIGH_EXP > HIGH_TOL) ?
                                         CNT_W'(HIGH_EXP - HIGH_TOL) :
                                         {CNT_W{1'b0}};
  localparam logic [RUN_W-1:0] LOCK_C  = RUN_W'(LOCK_COUNT);

  logic             rise;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] hi_cnt;
  logic [RUN_W-1:0] good_run;
  logic [RUN_W-1:0] good_run_inc;

  mon_state_t state_q;
  mon_state_t state_d;
  logic       capture;
  logic       stall_hit;
  logic       meas_good;
  logic       good_event;
  logic       bad_event;

  rise_detect u_rise (
    .clk  (clk_in),
    .rst  (rst),
    .d    (div_clk),
    .rise (rise)
  );

  // Measurement counters: both restart at 1 on the rising edge so that the
  // value held when the next edge arrives is the full period / high time.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else if (rise) begin
      per_cnt <= CNT_W'(1);
      hi_cnt  <= CNT_W'(1);
    end else begin
      if (per_cnt != TIMEOUT) begin
        per_cnt <= per_cnt + CNT_W'(1);
      end
      hi_cnt <= hi_cnt + CNT_W'(div_clk);
    end
  end

  assign meas_good = (per_cnt == DIV_C) && (hi_cnt >= HI_MIN) && (hi_cnt <= HI_MAX);

  // FSM state register
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q <= S_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state. Clear overrides everything, so an edge or timeout in
  // the same cycle is neither reported nor counted.
  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    stall_hit = 1'b0;
    if (clear) begin
      state_d = S_WAIT;
    end else begin
      case (state_q)
        S_WAIT: begin
          // First edge has no reference, so it only arms the measurement.
          if (rise) begin
            state_d = S_MEASURE;
          end else if (per_cnt == TIMEOUT) begin
            state_d   = S_STALL;
            stall_hit = 1'b1;
          end
        end
        S_MEASURE: begin
          if (rise) begin
            capture = 1'b1;
          end else if (per_cnt == TIMEOUT) begin
            state_d   = S_STALL;
            stall_hit = 1'b1;
          end
        end
        S_STALL: begin
          // Re-sync edge: restarts measurement without a report.
          if (rise) begin
            state_d = S_MEASURE;
          end
        end
        default: state_d = S_WAIT;
      endcase
    end
  end

  assign good_event   = capture & meas_good;
  assign bad_event    = (capture & ~meas_good) | stall_hit;
  assign good_run_inc = (good_run == LOCK_C) ? good_run : good_run + RUN_W'(1);

  // Reporting and status registers
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
      err_count  <= '0;
      stalled    <= 1'b0;
      good_run   <= '0;
    end else begin
      meas_valid <= capture;
      stalled    <= (state_d == S_STALL);
      if (capture) begin
        period    <= per_cnt;
        high_time <= hi_cnt;
      end
      if (clear) begin
        err       <= 1'b0;
        err_count <= '0;
        good_run  <= '0;
        locked    <= 1'b0;
      end else if (bad_event) begin
        err      <= 1'b1;
        good_run <= '0;
        locked   <= 1'b0;
        if (err_count != {ERR_CNT_W{1'b1}}) begin
          err_count <= err_count + ERR_CNT_W'(1);
        end
      end else if (good_event) begin
        good_run <= good_run_inc;
        locked   <= (good_run_inc == LOCK_C);
      end
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// -----------------------------------------------------------------------------
// tb_clk_div_monitor
// Directed bench for clk_div_monitor: a /4 instance (defaults) and a /5
// instance with HIGH_EXP=2, HIGH_TOL=1. A vector table covers lock-up and a
// stretched period; hand-written sequences cover stall, clear and async reset
// on the /4 instance and the tolerance window on the /5 instance.
// -----------------------------------------------------------------------------
module tb_clk_div_monitor;

  logic clk_in = 1'b0;
  logic rst;
  logic div4, div5, clr4, clr5;

  logic [7:0]  period4, high4, period5, high5;
  logic        mv4, lk4, er4, st4, mv5, lk5, er5, st5;
  logic [15:0] ec4, ec5;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk_in = ~clk_in;

  clk_div_monitor #(.DIV(4), .HIGH_EXP(2), .HIGH_TOL(0), .LOCK_COUNT(4), .CNT_W(8)) dut4 (
    .clk_in(clk_in), .rst(rst), .div_clk(div4), .clear(clr4),
    .period(period4), .high_time(high4), .meas_valid(mv4), .locked(lk4),
    .err(er4), .err_count(ec4), .stalled(st4)
  );

  clk_div_monitor #(.DIV(5), .HIGH_EXP(2), .HIGH_TOL(1), .LOCK_COUNT(4), .CNT_W(8)) dut5 (
    .clk_in(clk_in), .rst(rst), .div_clk(div5), .clear(clr5),
    .period(period5), .high_time(high5), .meas_valid(mv5), .locked(lk5),
    .err(er5), .err_count(ec5), .stalled(st5)
  );

  typedef struct {
    logic        div;
    logic        mv;
    logic [7:0]  per;
    logic [7:0]  hi;
    logic        lk;
    logic        er;
    logic [15:0] ec;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic d, input logic mv, input logic [7:0] per,
                     input logic [7:0] hi, input logic lk, input logic er,
                     input logic [15:0] ec);
    vec_t v;
    v.div = d; v.mv = mv; v.per = per; v.hi = hi; v.lk = lk; v.er = er; v.ec = ec;
    tbl.push_back(v);
  endtask

  task automatic step(input logic v4, input logic v5);
    div4 = v4;
    div5 = v5;
    @(posedge clk_in);
    #1;
  endtask

  // Snapshot layout: {mv, per[7:0], hi[7:0], lk, er, ec[15:0], st}
  task automatic compare(input string name, input logic [35:0] g, input logic [35:0] e);
    n_vec++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s: got mv=%0b per=%0d hi=%0d lk=%0b err=%0b ec=%0d st=%0b, expected mv=%0b per=%0d hi=%0d lk=%0b err=%0b ec=%0d st=%0b",
               name, g[35], g[34:27], g[26:19], g[18], g[17], g[16:1], g[0],
               e[35], e[34:27], e[26:19], e[18], e[17], e[16:1], e[0]);
    end
  endtask

  task automatic chk4(input string name, input logic mv, input logic [7:0] per,
                      input logic [7:0] hi, input logic lk, input logic er,
                      input logic [15:0] ec, input logic st);
    compare(name, {mv4, period4, high4, lk4, er4, ec4, st4}, {mv, per, hi, lk, er, ec, st});
  endtask

  task automatic chk5(input string name, input logic mv, input logic [7:0] per,
                      input logic [7:0] hi, input logic lk, input logic er,
                      input logic [15:0] ec, input logic st);
    compare(name, {mv5, period5, high5, lk5, er5, ec5, st5}, {mv, per, hi, lk, er, ec, st});
  endtask

  // One /5 period: first cycle is the rising edge (optionally with clear).
  task automatic p5_first(input logic clr);
    clr5 = clr;
    step(1'b0, 1'b1);
    clr5 = 1'b0;
  endtask

  task automatic p5_rest(input int h);
    for (int i = 1; i < 5; i++) begin
      step(1'b0, (i < h) ? 1'b1 : 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; div4 = 1'b0; div5 = 1'b0; clr4 = 1'b0; clr5 = 1'b0;

    // Clean 0011 pattern to lock, then a stretched 00011 period and recovery.
    add(0,0,0,0,0,0,0); add(0,0,0,0,0,0,0); add(1,0,0,0,0,0,0); add(1,0,0,0,0,0,0);
    add(0,0,0,0,0,0,0); add(0,0,0,0,0,0,0); add(1,1,4,2,0,0,0); add(1,0,4,2,0,0,0);
    add(0,0,4,2,0,0,0); add(0,0,4,2,0,0,0); add(1,1,4,2,0,0,0); add(1,0,4,2,0,0,0);
    add(0,0,4,2,0,0,0); add(0,0,4,2,0,0,0); add(1,1,4,2,0,0,0); add(1,0,4,2,0,0,0);
    add(0,0,4,2,0,0,0); add(0,0,4,2,0,0,0); add(1,1,4,2,1,0,0); add(1,0,4,2,1,0,0);
    add(0,0,4,2,1,0,0); add(0,0,4,2,1,0,0); add(0,0,4,2,1,0,0); add(1,1,5,2,0,1,1);
    add(1,0,5,2,0,1,1); add(0,0,5,2,0,1,1); add(0,0,5,2,0,1,1); add(1,1,4,2,0,1,1);
    add(1,0,4,2,0,1,1); add(0,0,4,2,0,1,1); add(0,0,4,2,0,1,1); add(1,1,4,2,0,1,1);
    add(1,0,4,2,0,1,1); add(0,0,4,2,0,1,1); add(0,0,4,2,0,1,1); add(1,1,4,2,0,1,1);
    add(1,0,4,2,0,1,1); add(0,0,4,2,0,1,1); add(0,0,4,2,0,1,1); add(1,1,4,2,1,1,1);

    repeat (2) @(posedge clk_in);
    #1;
    chk4("reset4", 0, 0, 0, 0, 0, 0, 0);
    chk5("reset5", 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].div, 1'b0);
      chk4($sformatf("vec%0d", i), tbl[i].mv, tbl[i].per, tbl[i].hi,
           tbl[i].lk, tbl[i].er, tbl[i].ec, 1'b0);
    end

    // Stall: high one more cycle, then 10 cycles low.
    step(1, 0);
    repeat (6) step(0, 0);
    chk4("stall_pre", 0, 4, 2, 1, 1, 1, 0);
    step(0, 0);
    chk4("stall_entry", 0, 4, 2, 0, 1, 2, 1);
    repeat (3) step(0, 0);
    chk4("stall_hold", 0, 4, 2, 0, 1, 2, 1);
    step(1, 0);
    chk4("stall_resync", 0, 4, 2, 0, 1, 2, 0);
    step(1, 0); step(0, 0); step(0, 0);
    step(1, 0);
    chk4("stall_after", 1, 4, 2, 0, 1, 2, 0);

    // Clear coincident with a bad (period 5) rise.
    step(1, 0); step(0, 0); step(0, 0); step(0, 0);
    clr4 = 1'b1;
    step(1, 0);
    clr4 = 1'b0;
    chk4("clear_bad_rise", 0, 4, 2, 0, 0, 0, 0);
    step(1, 0); step(0, 0); step(0, 0);
    step(1, 0);
    chk4("clear_first_rise", 0, 4, 2, 0, 0, 0, 0);
    step(1, 0); step(0, 0); step(0, 0);
    step(1, 0);
    chk4("clear_report", 1, 4, 2, 0, 0, 0, 0);

    // Asynchronous reset for 30 ns mid-period.
    step(1, 0); step(0, 0);
    rst = 1'b1;
    #1;
    chk4("rst_async", 0, 0, 0, 0, 0, 0, 0);
    step(0, 0);
    chk4("rst_hold_a", 0, 0, 0, 0, 0, 0, 0);
    step(1, 0);
    chk4("rst_hold_b", 0, 0, 0, 0, 0, 0, 0);
    step(1, 0);
    chk4("rst_hold_c", 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step(0, 0); step(0, 0);
    step(1, 0);
    chk4("rst_first_rise", 0, 0, 0, 0, 0, 0, 0);
    step(1, 0); step(0, 0); step(0, 0);
    step(1, 0);
    chk4("rst_report", 1, 4, 2, 0, 0, 0, 0);

    // /5 with +/-1 high-time tolerance; clear on the first edge.
    p5_first(1'b1);
    chk5("d5_clear", 0, 0, 0, 0, 0, 0, 0);
    p5_rest(2);
    p5_first(1'b0);
    chk5("d5_arm", 0, 0, 0, 0, 0, 0, 0);
    p5_rest(3);
    p5_first(1'b0);
    chk5("d5_hi3_a", 1, 5, 3, 0, 0, 0, 0);
    p5_rest(2);
    p5_first(1'b0);
    chk5("d5_hi2_a", 1, 5, 2, 0, 0, 0, 0);
    p5_rest(3);
    p5_first(1'b0);
    chk5("d5_hi3_b", 1, 5, 3, 0, 0, 0, 0);
    p5_rest(2);
    p5_first(1'b0);
    chk5("d5_lock", 1, 5, 2, 1, 0, 0, 0);
    p5_rest(4);
    p5_first(1'b0);
    chk5("d5_hi4_bad", 1, 5, 4, 0, 1, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
